// File: rtl/pipe_status_monitor_pkg.sv
// Shared Y86 encodings for the status monitor: one-hot stat codes, icodes, FSM state.
// The stat helper maps any malformed status onto INS.
package y86_pkg;

  localparam logic [0:3] STAT_AOK = 4'b1000;
  localparam logic [0:3] STAT_HLT = 4'b0100;
  localparam logic [0:3] STAT_ADR = 4'b0010;
  localparam logic [0:3] STAT_INS = 4'b0001;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } mon_state_t;

  // Anything that is not exactly one of the four legal codes is reported as INS.
  function automatic logic [0:3] norm_stat(input logic [0:3] s);
    case (s)
      STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS: norm_stat = s;
      default:                                norm_stat = STAT_INS;
    endcase
  endfunction

endpackage

// File: rtl/pipe_status_monitor_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != '1)) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipe_status_monitor.sv
// Writeback status monitor: registered run enable, latched final status, watchdog, perf counters.
// Define ICODE_HIST_EN to build the per-icode retire histogram.
module pipe_status_monitor
  import y86_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024,
  parameter int HIST_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:3]        W_stat,
  input  logic [3:0]        W_icode,
  input  logic              W_valid,
  input  logic              W_stall,
  input  logic              F_stall,
  input  logic              any_bubble,
  input  logic              cnt_clr,
  input  logic [3:0]        hist_sel,
  output logic              run_en,
  output logic              halted,
  output logic [0:3]        final_stat,
  output logic              wdog_trip,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [HIST_W-1:0] hist_cnt
);

  localparam bit WDOG_EN = (WDOG_CYCLES != 0);
  localparam int IDLE_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

  mon_state_t        state_reg;
  logic [IDLE_W-1:0] idle_reg;
  logic              run_en_reg;
  logic              halted_reg;
  logic [0:3]        final_stat_reg;
  logic              wdog_trip_reg;

  logic in_run;
  logic w_take;
  logic retire;
  logic fault;
  logic wdog_exp;

  assign in_run   = (state_reg == RUN);
  assign w_take   = W_valid & ~W_stall;
  assign retire   = in_run & w_take & (W_stat == STAT_AOK);
  assign fault    = in_run & w_take & (W_stat != STAT_AOK);
  assign wdog_exp = WDOG_EN & in_run & ~retire & (idle_reg == IDLE_MAX);

  // Fault is checked first so it wins over a simultaneous watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= RUN;
      idle_reg       <= '0;
      run_en_reg     <= 1'b1;
      halted_reg     <= 1'b0;
      final_stat_reg <= STAT_AOK;
      wdog_trip_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (fault) begin
            state_reg      <= STOP;
            run_en_reg     <= 1'b0;
            halted_reg     <= 1'b1;
            final_stat_reg <= norm_stat(W_stat);
            wdog_trip_reg  <= 1'b0;
          end else if (wdog_exp) begin
            state_reg      <= STOP;
            run_en_reg     <= 1'b0;
            halted_reg     <= 1'b1;
            final_stat_reg <= STAT_AOK;
            wdog_trip_reg  <= 1'b1;
          end else if (retire) begin
            idle_reg <= '0;
          end else if (WDOG_EN) begin
            idle_reg <= idle_reg + IDLE_W'(1);
          end
        end
        default: begin
          state_reg <= STOP;
        end
      endcase
    end
  end

  assign run_en     = run_en_reg;
  assign halted     = halted_reg;
  assign final_stat = final_stat_reg;
  assign wdog_trip  = wdog_trip_reg;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(in_run), .q(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(retire), .q(retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(in_run & F_stall), .q(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(in_run & any_bubble), .q(bubble_cnt)
  );

`ifdef ICODE_HIST_EN
  logic [HIST_W-1:0] hist_q [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hist
      sat_counter #(.W(HIST_W)) u_hist (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(retire & (W_icode == 4'(gi))),
        .q(hist_q[gi])
      );
    end
  endgenerate

  assign hist_cnt = hist_q[hist_sel];
`else
  logic unused_hist;
  assign unused_hist = ^{hist_sel, W_icode};
  assign hist_cnt    = '0;
`endif

endmodule

// File: doc/pipe_status_monitor.md
Name: pipe_status_monitor

Overview:
- Parametrised successor to the processor's built-in halt check. It moves stat-driven termination into a registered, reusable block.
- Sits beside the pipeline control unit and watches the writeback stage (W_stat, W_icode, valid) plus the stall/bubble controls.
- Produces a registered run enable that freezes the pipeline, a latched final status, a watchdog, and saturating performance counters.

Parameters:
- CNT_W, 32, width of every performance counter.
- WDOG_CYCLES, 1024, consecutive cycles with no retirement before a watchdog stop; 0 disables the watchdog.
- HIST_W, 16, width of each icode histogram counter (used only with ICODE_HIST_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- W_stat  in  4 [0:3]  writeback status, one-hot: AOK=1000, HLT=0100, ADR=0010, INS=0001.
- W_icode  in  4  writeback icode.
- W_valid  in  1  writeback holds a real instruction (0 = bubble).
- W_stall  in  1  writeback stage stalled this cycle.
- F_stall  in  1  fetch stall from pipe control.
- any_bubble  in  1  OR of D_bubble, E_bubble, M_bubble.
- cnt_clr  in  1  synchronous clear of all counters.
- hist_sel  in  4  histogram read select.
- run_en  out  1  pipeline advance enable; registered.
- halted  out  1  block is in the STOP state.
- final_stat  out  4 [0:3]  latched terminating status.
- wdog_trip  out  1  the stop was caused by the watchdog.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- retire_cnt  out  CNT_W  retired instructions.
- stall_cnt  out  CNT_W  cycles with F_stall=1.
- bubble_cnt  out  CNT_W  cycles with any_bubble=1.
- hist_cnt  out  HIST_W  retire count for icode hist_sel.

Behaviour:
- Reset values (asynchronous, immediate): state RUN, run_en=1, halted=0, final_stat=1000, wdog_trip=0, all counters 0.
- Retire event: W_valid & !W_stall & W_stat==AOK in a RUN cycle.
- Fault event: W_valid & !W_stall & W_stat!=AOK.
  - Any W_stat that is not one-hot, or is 0000, is treated as INS (0001).
- FSM has two states, RUN and STOP.
- RUN -> STOP on the clock edge that samples a fault event.
  - On that same edge: final_stat latches the (normalised) status, run_en=0, halted=1.
  - Latency is one cycle from W_stat valid to run_en low.
- Watchdog: an idle counter increments each RUN cycle without a retire event and resets to 0 on a retire event.
  - When it reaches WDOG_CYCLES-1 and the current cycle has no retire: go to STOP with wdog_trip=1 and final_stat=1000.
- Fault and watchdog expiry in the same cycle: the fault wins, wdog_trip=0.
- STOP is terminal until rst. All W_* inputs are ignored and counters are frozen; cnt_clr still clears them.
- Counters increment only in RUN:
  - cycle_cnt increments every RUN cycle, including the cycle that samples the fault.
  - retire_cnt increments on retire events only; the faulting instruction is not counted.
  - stall_cnt and bubble_cnt increment on their respective input levels.
- All counters saturate at all-ones and never wrap.
- cnt_clr together with an increment: the clear wins and the result is 0. cnt_clr does not affect the FSM, the idle counter or final_stat.
- rst asserted mid-operation, including in STOP, returns everything to reset values immediately.

Optional Feature:
- Macro: ICODE_HIST_EN.
- Defined: 16 saturating HIST_W counters indexed by W_icode, each incremented on a retire event and cleared by cnt_clr or rst. hist_cnt = counter[hist_sel], combinational read.
- Undefined: no histogram storage; hist_cnt is tied to 0.

Decomposition:
- Shared package (y86_pkg):
  - stat encodings STAT_AOK/HLT/ADR/INS.
  - icode constants (HALT=0, NOP=1, ... POPQ=11).
  - the state typedef {RUN, STOP}.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, clr, inc; output q). It is instantiated for the four performance counters and each histogram entry.

Test Plan:
- Reset, then 10 retire cycles of AOK with W_valid=1 -> retire_cnt=10, cycle_cnt=10, run_en=1, halted=0.
- HLT (0100) with W_valid=1 at cycle 5 -> run_en=0 at the next edge, final_stat=0100, retire_cnt=4, cycle_cnt=5, counters frozen for 20 further cycles.
- WDOG_CYCLES=8, W_valid held at 0 -> STOP after exactly 8 cycles, wdog_trip=1, final_stat=1000. Repeat with ADR arriving on the 8th idle cycle -> wdog_trip=0, final_stat=0010.
- W_stat=0110 with W_valid=1 -> final_stat=0001. Same W_stat with W_valid=0 or W_stall=1 -> ignored, stays in RUN.
- CNT_W=4, F_stall held for 20 cycles -> stall_cnt sticks at 15. cnt_clr pulsed alongside F_stall -> stall_cnt=0, then 1 on the following cycle.
- With ICODE_HIST_EN: retire 3 OPq (icode 6) and 2 IRMOVQ (icode 3) -> hist_sel=6 gives 3, hist_sel=3 gives 2. Assert rst while in STOP -> all outputs return to reset values within the same cycle.
